polynomial_hash_multi: RTL and testbench

- Parametrised successor to the single-configuration polynomial hash.
- Evaluates a byte-stream message as a polynomial over GF(p), p = 2^31-1 (Mersenne prime), using Horner's rule.
- Runs NUM_KEYS independent 31-bit key lanes in parallel, one byte per cycle; message end is marked by ss_tlast instead of a separate post-stream start.
- Sits between the message byte source and the authentication tag comparator; produces one 32-bit tag per lane.

---
 rtl/polynomial_hash_multi.sv | 120 ++++++++++++
 tb/tb_polynomial_hash_multi.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/polynomial_hash_multi.sv
// rtl/polynomial_hash_multi.sv - multi-lane Horner polynomial hash over GF(2^31-1)
// Define POLYNOMIAL_LENGTH_FOLD_EN to append a final length-fold step to every tag.
module polynomial_hash_multi #(
    parameter int NUM_KEYS = 6,
    parameter int LEN_W    = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [7:0]              ss_tdata,
    input  logic                    ss_tvalid,
    output logic                    ss_tready,
    input  logic                    ss_tlast,
    input  logic [31*NUM_KEYS-1:0]  polynomial_key,
    output logic [32*NUM_KEYS-1:0]  sm_tdata,
    output logic                    sm_tvalid,
    input  logic                    sm_tready,
    output logic                    busy
);

    localparam logic [30:0] P = 31'h7FFF_FFFF;

    typedef enum logic [1:0] {S_IDLE, S_ABSORB, S_FOLD, S_OUT} state_t;

    state_t state_q, state_d;
    logic [NUM_KEYS-1:0][30:0] acc_q, acc_d;
    logic [NUM_KEYS-1:0][30:0] key_q, key_d;
    logic [NUM_KEYS-1:0][30:0] tag_q, tag_d;
    logic beat;

    // (a*k + addend) mod p: fold the 62-bit sum at bit 31, then at most two subtractions.
    function automatic logic [30:0] mod_step(input logic [30:0] a, input logic [30:0] k,
                                             input logic [30:0] addend);
        logic [61:0] t;
        logic [31:0] s;
        t = {31'b0, a} * {31'b0, k} + {31'b0, addend};
        s = {1'b0, t[30:0]} + {1'b0, t[61:31]};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[30:0];
    endfunction

`ifdef POLYNOMIAL_LENGTH_FOLD_EN
    logic [LEN_W-1:0] len_q, len_d;
    logic [30:0]      len_ext;
    assign len_ext = 31'(len_q);
`endif

    assign beat = (state_q == S_ABSORB) && ss_tvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            key_q   <= '0;
            tag_q   <= '0;
`ifdef POLYNOMIAL_LENGTH_FOLD_EN
            len_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            key_q   <= key_d;
            tag_q   <= tag_d;
`ifdef POLYNOMIAL_LENGTH_FOLD_EN
            len_q   <= len_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ABSORB;
            S_ABSORB: if (ss_tvalid && ss_tlast) begin
`ifdef POLYNOMIAL_LENGTH_FOLD_EN
                state_d = S_FOLD;
`else
                state_d = S_OUT;
`endif
            end
            S_FOLD:   state_d = S_OUT;
            S_OUT:    if (sm_tready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        key_d = key_q;
        tag_d = tag_q;
`ifdef POLYNOMIAL_LENGTH_FOLD_EN
        len_d = len_q;
        if ((state_q == S_IDLE) && start) len_d = '0;
        else if (beat)                    len_d = len_q + 1'b1;
`endif
        for (int i = 0; i < NUM_KEYS; i++) begin
            if ((state_q == S_IDLE) && start) begin
                key_d[i] = (polynomial_key[31*i +: 31] == P) ? 31'd0 : polynomial_key[31*i +: 31];
                acc_d[i] = '0;
            end else if (beat) begin
                acc_d[i] = mod_step(acc_q[i], key_q[i], {23'b0, ss_tdata});
`ifdef POLYNOMIAL_LENGTH_FOLD_EN
            end else if (state_q == S_FOLD) begin
                acc_d[i] = mod_step(acc_q[i], key_q[i], len_ext);
`endif
            end
        end
        // Tags are captured once on entry to OUT so they survive the next start.
        if ((state_d == S_OUT) && (state_q != S_OUT)) tag_d = acc_d;
    end

    always_comb begin
        ss_tready = (state_q == S_ABSORB);
        sm_tvalid = (state_q == S_OUT);
        busy      = (state_q != S_IDLE);
        for (int i = 0; i < NUM_KEYS; i++) sm_tdata[32*i +: 32] = {1'b0, tag_q[i]};
    end

endmodule

// File: tb/tb_polynomial_hash_multi.sv
// tb/tb_polynomial_hash_multi.sv - directed and randomized bench for polynomial_hash_multi
module tb_polynomial_hash_multi;

    localparam int NK    = 6;
    localparam int LEN_W = 24;
    localparam longint unsigned P = 64'h7FFF_FFFF;
`ifdef POLYNOMIAL_LENGTH_FOLD_EN
    localparam int  LAT  = 2;
    localparam bit  FOLD = 1'b1;
`else
    localparam int  LAT  = 1;
    localparam bit  FOLD = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [7:0]         ss_tdata = '0;
    logic               ss_tvalid = 1'b0;
    logic               ss_tready;
    logic               ss_tlast = 1'b0;
    logic [31*NK-1:0]   polynomial_key = '0;
    logic [32*NK-1:0]   sm_tdata;
    logic               sm_tvalid;
    logic               sm_tready = 1'b0;
    logic               busy;

    int errors = 0;
    int checks = 0;
    logic [30:0] keys [NK];
    logic [7:0]  msg [$];

    polynomial_hash_multi #(.NUM_KEYS(NK), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ss_tdata(ss_tdata), .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tlast(ss_tlast),
        .polynomial_key(polynomial_key),
        .sm_tdata(sm_tdata), .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Plain modular arithmetic over the whole message, independent of any hardware structure.
    function automatic logic [31:0] model_tag(input logic [30:0] key);
        longint unsigned acc, k, n;
        acc = 0;
        k = (key == 31'h7FFF_FFFF) ? 0 : longint'(key);
        foreach (msg[j]) acc = (acc * k + longint'(msg[j])) % P;
        if (FOLD) begin
            n = longint'(msg.size()) % (64'd1 << LEN_W);
            acc = (acc * k + n) % P;
        end
        return {1'b0, acc[30:0]};
    endfunction

    task automatic do_start();
        @(negedge clk);
        for (int i = 0; i < NK; i++) polynomial_key[31*i +: 31] = keys[i];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < NK; i++) polynomial_key[31*i +: 31] = 31'($urandom());
        check32("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    task automatic send_msg(input int stall_pct, input int mid_start_at, input int stop_at);
        int i = 0;
        int cyc = 0;
        while (i < stop_at && cyc < 40000) begin
            start = 1'b0;
            if ($urandom_range(99) < stall_pct) begin
                ss_tvalid = 1'b0;
                ss_tlast  = 1'b0;
            end else begin
                ss_tvalid = 1'b1;
                ss_tdata  = msg[i];
                ss_tlast  = (i == msg.size() - 1);
                if (i == mid_start_at) start = 1'b1;
                if (ss_tready) i++;
            end
            @(negedge clk);
            cyc++;
        end
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
        start     = 1'b0;
        check32("bytes_accepted", i, stop_at);
    endtask

    task automatic run_msg(input string name, input int stall_pct, input int mid_start_at,
                           input int hold, input bit chk0, input logic [31:0] exp0);
        logic [31:0] exp [NK];
        int lat;
        for (int i = 0; i < NK; i++) exp[i] = model_tag(keys[i]);
        do_start();
        send_msg(stall_pct, mid_start_at, msg.size());
        lat = 1;
        while (!sm_tvalid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check32({name, "_latency"}, lat, LAT);
        for (int i = 0; i < NK; i++)
            check32($sformatf("%s_lane%0d", name, i), sm_tdata[32*i +: 32], exp[i]);
        if (chk0) check32({name, "_lane0_const"}, sm_tdata[31:0], exp0);
        for (int h = 0; h < hold; h++) begin
            check32({name, "_hold_valid"}, {31'b0, sm_tvalid}, 32'd1);
            check32({name, "_hold_data"}, sm_tdata[31:0], exp[0]);
            @(negedge clk);
        end
        sm_tready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        sm_tready = 1'b0;
        start     = 1'b0;
        check32({name, "_valid_drop"}, {31'b0, sm_tvalid}, 32'd0);
        check32({name, "_idle_after"}, {31'b0, busy}, 32'd0);
        check32({name, "_data_kept"}, sm_tdata[31:0], exp[0]);
    endtask

    initial begin
        #3;
        check32("reset_tready", {31'b0, ss_tready}, 32'd0);
        check32("reset_tvalid", {31'b0, sm_tvalid}, 32'd0);
        check32("reset_busy", {31'b0, busy}, 32'd0);
        check32("reset_tdata_lo", sm_tdata[31:0], 32'd0);
        check32("reset_tdata_hi", sm_tdata[32*NK-1 -: 32], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NK; i++) keys[i] = 31'($urandom());
        keys[0] = 31'd2;
        msg = '{8'd1, 8'd2, 8'd3};
        run_msg("k2", 0, -1, 0, 1'b1, FOLD ? 32'h19 : 32'h0B);

        keys[0] = 31'h7FFF_FFFE;
        msg = '{8'd5, 8'd7};
        run_msg("kneg1", 20, -1, 0, 1'b1, FOLD ? 32'h0 : 32'h2);

        keys[0] = 31'h7FFF_FFFF;
        msg = '{8'd9, 8'd4};
        run_msg("kzero", 0, -1, 0, 1'b1, FOLD ? 32'h2 : 32'h4);

        for (int i = 0; i < NK; i++) keys[i] = 31'(i + 1);
        msg = '{8'hFF};
        run_msg("ff6", 0, -1, 5, 1'b1, FOLD ? 32'd256 : 32'd255);
        check32("ff6_lane5_const", sm_tdata[32*5 +: 32], FOLD ? 32'd1531 : 32'd255);

        for (int i = 0; i < NK; i++) keys[i] = 31'($urandom());
        keys[0] = 31'h7FFF_FFFE;
        keys[1] = 31'h7FFF_FFFF;
        msg.delete();
        for (int j = 0; j < 12500; j++) msg.push_back(8'($urandom_range(255)));
        run_msg("rand", 30, 5000, 0, 1'b0, 32'd0);

        msg.delete();
        for (int j = 0; j < 300; j++) msg.push_back(8'($urandom_range(255)));
        do_start();
        send_msg(10, -1, 100);
        #2;
        rst_n = 1'b0;
        #1;
        check32("abort_tready", {31'b0, ss_tready}, 32'd0);
        check32("abort_tvalid", {31'b0, sm_tvalid}, 32'd0);
        check32("abort_busy", {31'b0, busy}, 32'd0);
        check32("abort_tdata", sm_tdata[31:0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        keys[0] = 31'd2;
        msg = '{8'd1, 8'd2, 8'd3};
        run_msg("after_abort", 0, -1, 0, 1'b1, FOLD ? 32'h19 : 32'h0B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
